// File: rtl/if_id_stall_pipe.sv
// PC register and IF/ID pipeline register for the fetch side of the
// load-use stall protocol. Holds on stall, bubbles on flush, advances
// otherwise. Also keeps saturating stall/flush statistics and a sticky
// watchdog that trips on runaway consecutive stalls.
module if_id_stall_pipe #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned STALL_LIMIT = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,        // active-low, asynchronous
  input  logic [31:0]      pc_next_i,
  input  logic [31:0]      inst_i,
  input  logic             hazard_i,
  input  logic             flush_i,
  input  logic             clr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      ifid_pc4_o,
  output logic [31:0]      ifid_inst_o,
  output logic             ifid_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             stall_err_o
);

  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [7:0]       Limit    = 8'(STALL_LIMIT);
  localparam logic [7:0]       ConsecMx = 8'hFF;
  localparam logic [31:0]      Nop      = 32'h0000_0000;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ifid_pc4_q, ifid_pc4_d;
  logic [31:0]      ifid_inst_q, ifid_inst_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [7:0]       consec_q, consec_d;
  logic             stall_err_q, stall_err_d;
  logic             take_flush;

  // Stall wins over flush: the stalled ID instruction re-resolves its branch later.
  assign take_flush = !hazard_i && flush_i;

  // Pipeline next state: hold on stall, NOP bubble on flush, advance otherwise.
  always_comb begin
    pc_d         = pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_valid_d = ifid_valid_q;
    if (!hazard_i) begin
      pc_d       = pc_next_i;
      ifid_pc4_d = pc_q + 32'd4;
      if (take_flush) begin
        ifid_inst_d  = Nop;
        ifid_valid_d = 1'b0;
      end else begin
        ifid_inst_d  = inst_i;
        ifid_valid_d = 1'b1;
      end
    end
  end

  // Statistics and watchdog next state; clear overrides any increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    consec_d    = 8'h00;
    stall_err_d = stall_err_q;
    if (hazard_i && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (take_flush && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
    if (hazard_i) begin
      consec_d = (consec_q == ConsecMx) ? ConsecMx : consec_q + 8'd1;
    end
    if (hazard_i && (consec_d == Limit)) begin
      stall_err_d = 1'b1;
    end
    if (clr_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
      consec_d    = 8'h00;
      stall_err_d = 1'b0;
    end
  end

  // PC and IF/ID registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q         <= RESET_PC;
      ifid_pc4_q   <= 32'h0;
      ifid_inst_q  <= Nop;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // Counter and watchdog registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      consec_q    <= 8'h00;
      stall_err_q <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      consec_q    <= consec_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign pc_o         = pc_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign ifid_inst_o  = ifid_inst_q;
  assign ifid_valid_o = ifid_valid_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
  assign stall_err_o  = stall_err_q;

endmodule

// File: tb/tb_if_id_stall_pipe.sv
// Directed bench for if_id_stall_pipe. A second instance with 4-bit
// counters shares the stimulus to exercise counter saturation.
module tb_if_id_stall_pipe;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] pc_next_i, inst_i;
  logic        hazard_i, flush_i, clr_i;

  logic [31:0] pc_o, ifid_pc4_o, ifid_inst_o;
  logic        ifid_valid_o, stall_err_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  logic [31:0] s_pc, s_pc4, s_inst;
  logic        s_valid, s_err;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [96:0] got, exp;

  localparam logic [31:0] I0 = 32'hA000_0001, I1 = 32'hA000_0002, I2 = 32'hA000_0003;
  localparam logic [31:0] I3 = 32'hB000_0004, I4 = 32'hB000_0005, I5 = 32'hB000_0006;
  localparam logic [31:0] I6 = 32'hC000_0007, I7 = 32'hC000_0008, I8 = 32'hD000_0009;
  localparam logic [31:0] I9 = 32'hD000_000A, JUNK = 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  if_id_stall_pipe #(.RESET_PC(32'h0), .CNT_W(16), .STALL_LIMIT(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .pc_next_i(pc_next_i), .inst_i(inst_i),
    .hazard_i(hazard_i), .flush_i(flush_i), .clr_i(clr_i),
    .pc_o(pc_o), .ifid_pc4_o(ifid_pc4_o), .ifid_inst_o(ifid_inst_o),
    .ifid_valid_o(ifid_valid_o), .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o), .stall_err_o(stall_err_o)
  );

  if_id_stall_pipe #(.RESET_PC(32'h0), .CNT_W(4), .STALL_LIMIT(8)) dut_small (
    .clk_i(clk), .rst_i(rst_i), .pc_next_i(pc_next_i), .inst_i(inst_i),
    .hazard_i(hazard_i), .flush_i(flush_i), .clr_i(clr_i),
    .pc_o(s_pc), .ifid_pc4_o(s_pc4), .ifid_inst_o(s_inst),
    .ifid_valid_o(s_valid), .stall_cnt_o(s_stall_cnt),
    .flush_cnt_o(s_flush_cnt), .stall_err_o(s_err)
  );

  // Apply one edge with the given inputs and land 1ns after it.
  task automatic edge_in(input logic h, input logic f, input logic c,
                         input logic [31:0] pn, input logic [31:0] in);
    hazard_i  = h;
    flush_i   = f;
    clr_i     = c;
    pc_next_i = pn;
    inst_i    = in;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    hazard_i = 1'b0; flush_i = 1'b0; clr_i = 1'b0; pc_next_i = 32'h44; inst_i = JUNK;
    repeat (2) @(posedge clk);
    #1;
    got = {pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o};
    exp = {32'h0, 32'h0, 32'h0, 1'b0};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL reset_pipe: got %h want %h", got, exp);
    end
    n_checks++;
    if ({stall_cnt_o, flush_cnt_o, stall_err_o} !== 33'h0) begin
      n_fail++; $display("FAIL reset_cnt: got %h/%h/%b want 0/0/0", stall_cnt_o, flush_cnt_o,
                         stall_err_o);
    end
    #3 rst_i = 1'b1;
    #1;
    n_checks++;
    if (pc_o !== 32'h0 || ifid_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_hold: pc %h valid %b want 0 0", pc_o, ifid_valid_o);
    end
  endtask

  task automatic test_normal();
    edge_in(1'b0, 1'b0, 1'b0, 32'h4, I0);
    got = {pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o};
    exp = {32'h4, 32'h4, I0, 1'b1};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL normal_e1: got %h want %h", got, exp);
    end
    edge_in(1'b0, 1'b0, 1'b0, 32'h8, I1);
    n_checks++;
    if (pc_o !== 32'h8 || ifid_inst_o !== I1) begin
      n_fail++; $display("FAIL normal_e2: pc %h inst %h want 8 %h", pc_o, ifid_inst_o, I1);
    end
    edge_in(1'b0, 1'b0, 1'b0, 32'hC, I2);
    got = {pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o};
    exp = {32'hC, 32'hC, I2, 1'b1};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL normal_e3: got %h want %h", got, exp);
    end
  endtask

  task automatic test_stall();
    edge_in(1'b1, 1'b0, 1'b0, 32'h100, JUNK);
    got = {pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o};
    exp = {32'hC, 32'hC, I2, 1'b1};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL stall_hold: got %h want %h", got, exp);
    end
    n_checks++;
    if (stall_cnt_o !== 16'd1) begin
      n_fail++; $display("FAIL stall_cnt1: got %0d want 1", stall_cnt_o);
    end
    edge_in(1'b0, 1'b0, 1'b0, 32'h10, I3);
    got = {pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o};
    exp = {32'h10, 32'h10, I3, 1'b1};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL stall_resume: got %h want %h", got, exp);
    end
  endtask

  task automatic test_flush();
    edge_in(1'b0, 1'b1, 1'b0, 32'h40, JUNK);
    got = {pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o};
    exp = {32'h40, 32'h14, 32'h0, 1'b0};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL flush_pipe: got %h want %h", got, exp);
    end
    n_checks++;
    if (flush_cnt_o !== 16'd1 || stall_cnt_o !== 16'd1) begin
      n_fail++; $display("FAIL flush_cnt: flush %0d stall %0d want 1 1", flush_cnt_o, stall_cnt_o);
    end
  endtask

  task automatic test_stall_and_flush();
    edge_in(1'b1, 1'b1, 1'b0, 32'h80, JUNK);
    got = {pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o};
    exp = {32'h40, 32'h14, 32'h0, 1'b0};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL sf_hold: got %h want %h", got, exp);
    end
    n_checks++;
    if (flush_cnt_o !== 16'd1 || stall_cnt_o !== 16'd2) begin
      n_fail++; $display("FAIL sf_cnt: flush %0d stall %0d want 1 2", flush_cnt_o, stall_cnt_o);
    end
    edge_in(1'b0, 1'b0, 1'b0, 32'h44, I4);
    got = {pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o};
    exp = {32'h44, 32'h44, I4, 1'b1};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL sf_resume: got %h want %h", got, exp);
    end
  endtask

  task automatic test_watchdog();
    for (int i = 0; i < 7; i++) edge_in(1'b1, 1'b0, 1'b0, 32'h200, JUNK);
    n_checks++;
    if (stall_err_o !== 1'b0) begin
      n_fail++; $display("FAIL wd_7: err %b want 0", stall_err_o);
    end
    edge_in(1'b1, 1'b0, 1'b0, 32'h200, JUNK);
    n_checks++;
    if (stall_err_o !== 1'b1 || stall_cnt_o !== 16'd10 || s_stall_cnt !== 4'd10) begin
      n_fail++; $display("FAIL wd_8: err %b cnt %0d/%0d want 1 10/10", stall_err_o, stall_cnt_o,
                         s_stall_cnt);
    end
    n_checks++;
    if (pc_o !== 32'h44 || ifid_inst_o !== I4) begin
      n_fail++; $display("FAIL wd_frozen: pc %h inst %h want 44 %h", pc_o, ifid_inst_o, I4);
    end
    edge_in(1'b0, 1'b0, 1'b0, 32'h48, I5);
    n_checks++;
    if (stall_err_o !== 1'b1 || pc_o !== 32'h48) begin
      n_fail++; $display("FAIL wd_sticky: err %b pc %h want 1 48", stall_err_o, pc_o);
    end
    edge_in(1'b0, 1'b0, 1'b1, 32'h4C, I6);
    n_checks++;
    if ({stall_err_o, stall_cnt_o, flush_cnt_o} !== 33'h0) begin
      n_fail++; $display("FAIL wd_clr: err %b stall %0d flush %0d want 0 0 0", stall_err_o,
                         stall_cnt_o, flush_cnt_o);
    end
    n_checks++;
    if (pc_o !== 32'h4C || ifid_inst_o !== I6 || ifid_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL wd_clr_pipe: pc %h inst %h v %b want 4c %h 1", pc_o, ifid_inst_o,
                         ifid_valid_o, I6);
    end
    for (int i = 0; i < 7; i++) edge_in(1'b1, 1'b0, 1'b0, 32'h300, JUNK);
    edge_in(1'b0, 1'b0, 1'b0, 32'h50, I7);
    for (int i = 0; i < 7; i++) edge_in(1'b1, 1'b0, 1'b0, 32'h300, JUNK);
    n_checks++;
    if (stall_err_o !== 1'b0 || stall_cnt_o !== 16'd14) begin
      n_fail++; $display("FAIL wd_broken_run: err %b cnt %0d want 0 14", stall_err_o, stall_cnt_o);
    end
    edge_in(1'b1, 1'b0, 1'b1, 32'h300, JUNK);
    n_checks++;
    if (stall_cnt_o !== 16'd0 || stall_err_o !== 1'b0 || pc_o !== 32'h50) begin
      n_fail++; $display("FAIL clr_override: cnt %0d err %b pc %h want 0 0 50", stall_cnt_o,
                         stall_err_o, pc_o);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) edge_in(1'b1, 1'b0, 1'b0, 32'h400, JUNK);
    n_checks++;
    if (s_stall_cnt !== 4'd15 || stall_cnt_o !== 16'd20) begin
      n_fail++; $display("FAIL sat: small %0d big %0d want 15 20", s_stall_cnt, stall_cnt_o);
    end
    n_checks++;
    if (stall_err_o !== 1'b1 || pc_o !== 32'h50 || ifid_inst_o !== I7) begin
      n_fail++; $display("FAIL sat_frozen: err %b pc %h inst %h want 1 50 %h", stall_err_o, pc_o,
                         ifid_inst_o, I7);
    end
  endtask

  task automatic test_reset_mid_stall();
    #2 rst_i = 1'b0;
    #1;
    got = {pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o};
    exp = {32'h0, 32'h0, 32'h0, 1'b0};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL rst_mid_pipe: got %h want %h", got, exp);
    end
    n_checks++;
    if ({stall_cnt_o, flush_cnt_o, stall_err_o, s_stall_cnt} !== 37'h0) begin
      n_fail++; $display("FAIL rst_mid_cnt: %0d %0d %b %0d want all 0", stall_cnt_o, flush_cnt_o,
                         stall_err_o, s_stall_cnt);
    end
    hazard_i = 1'b0;
    #2 rst_i = 1'b1;
  endtask

  task automatic test_wrap();
    edge_in(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, I8);
    got = {pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o};
    exp = {32'hFFFF_FFFC, 32'h4, I8, 1'b1};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL wrap_load: got %h want %h", got, exp);
    end
    edge_in(1'b0, 1'b0, 1'b0, 32'h0, I9);
    got = {pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o};
    exp = {32'h0, 32'h0, I9, 1'b1};
    n_checks++;
    if (got !== exp) begin
      n_fail++; $display("FAIL wrap_pc4: got %h want %h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_stall();
    test_flush();
    test_stall_and_flush();
    test_watchdog();
    test_saturation();
    test_reset_mid_stall();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
